mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported 128-bit block data memory (28-bit block address, READ/WRITE/BUSYWAIT handshake).
- Port 0 is the instruction-cache refill path and port 1 is the data-cache refill/writeback path.
- The block grants one requester at a time, registers and drives the memory command, tracks the memory BUSYWAIT, returns read blocks, and releases the winner with a one-cycle BUSYWAIT-low window.

Parameters:
ARB_MODE, 1, 0 = fixed priority to PRIORITY_PORT, 1 = round-robin.
PRIORITY_PORT, 1, port that wins fixed-priority ties.
TIMEOUT_CYCLES, 64, ACCESS-state cycle limit before ERROR is flagged.

Ports:
CLOCK  in  1  single clock, all state on posedge.
RESET  in  1  asynchronous, active-high reset.
READ0 / WRITE0  in  1 each  port 0 request.
ADDRESS0  in  28  port 0 block address.
WRITEDATA0  in  128  port 0 write block.
READDATA0  out  128  port 0 returned block, registered.
BUSYWAIT0  out  1  port 0 stall.
READ1 / WRITE1 / ADDRESS1 / WRITEDATA1 / READDATA1 / BUSYWAIT1  same as port 0, for port 1.
MEM_READ  out  1  memory read strobe, registered.
MEM_WRITE  out  1  memory write strobe, registered.
MEM_ADDRESS  out  28  registered.
MEM_WRITEDATA  out  128  registered.
MEM_READDATA  in  128  memory read block.
MEM_BUSYWAIT  in  1  memory busy.
ERROR  out  1  sticky timeout flag.

Behaviour:
- Request validity: VALIDn = READn XOR WRITEn. READ and WRITE both high counts as no request; this matches the memory, which ignores that combination.
- BUSYWAITn is combinational: VALIDn AND NOT (state==DONE AND grant==n). It rises in the same cycle the request rises.
- Reset (asynchronous, any state including mid-access):
  - state=IDLE.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - READDATA0=READDATA1=0, ERROR=0.
  - last_grant=0, grant=0, cycle counter=0.
  - The memory strobes drop immediately, without waiting for a clock edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No valid request: stay.
  - Exactly one valid request: that port wins.
  - Both valid, ARB_MODE=0: PRIORITY_PORT wins.
  - Both valid, ARB_MODE=1: the port not equal to last_grant wins.
  - On a win, at the posedge:
    - latch grant; set last_grant=grant.
    - MEM_ADDRESS<=ADDRESSg, MEM_WRITEDATA<=WRITEDATAg.
    - MEM_READ<=READg, MEM_WRITE<=WRITEg.
    - counter<=1; go to ACCESS.
- ACCESS:
  - Memory strobes held constant.
  - Requester inputs are ignored; they are stable by handshake.
  - counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - Exit at the first posedge where counter>=2 AND MEM_BUSYWAIT==0. This tolerates the memory raising BUSYWAIT combinationally one cycle after the strobe.
  - On exit:
    - if MEM_READ: READDATAg<=MEM_READDATA.
    - MEM_READ<=0, MEM_WRITE<=0; go to DONE.
  - If counter reaches TIMEOUT_CYCLES with MEM_BUSYWAIT still 1:
    - ERROR<=1 (sticky until reset).
    - strobes dropped; go to DONE.
    - READDATAg is not updated.
- DONE (exactly 1 cycle): BUSYWAITg=0, so the requester consumes READDATAg and drops or changes its request. Next posedge: go to IDLE.
- Latency: grant edge to DONE is at least 2 cycles, plus memory time. The losing port stays stalled and is served on the IDLE following DONE.
- A request withdrawn (VALID falls) while in ACCESS does not abort; the access completes.
- A new request from the just-served port in IDLE is arbitrated normally. In round-robin mode the other waiting port wins first.
- READDATA of the non-granted port never changes.
- The block never issues a command while MEM_READ or MEM_WRITE is high (one outstanding access).

Test Plan:
- Reset, single read: READ0=1, ADDRESS0=28'h0000010, memory preloaded with block 128'hA5…A5, memory BUSYWAIT 5 cycles → MEM_READ=1 and MEM_ADDRESS=28'h0000010 one edge after request. READDATA0=128'hA5…A5 captured on exit. BUSYWAIT0 low for exactly 1 cycle. MEM_READ=0 in DONE.
- Simultaneous requests, ARB_MODE=1: READ0 addr 28'h1 and WRITE1 addr 28'h2 data 128'h1234 raised in the same cycle, last_grant=0 after reset → port 1 write issued first, then port 0 read. BUSYWAIT0 stays high through both accesses. The memory then holds 128'h1234 at block 2.
- Fixed priority, ARB_MODE=0, PRIORITY_PORT=1: port 1 keeps reissuing reads back-to-back → port 0 starves. BUSYWAIT0 stays 1 for the whole window.
- Illegal request: READ1=WRITE1=1 → BUSYWAIT1=0, no memory strobe, state stays IDLE.
- Timeout, TIMEOUT_CYCLES=8: memory BUSYWAIT held at 1 → ERROR=1 after 8 ACCESS cycles. DONE is entered and READDATA is unchanged. ERROR stays 1 through later normal accesses until RESET.
- Reset mid-ACCESS: assert RESET 3 cycles into a port-0 read → MEM_READ drops without waiting for an edge. READDATA0=0, ERROR=0. After RESET deasserts, a pending port-1 request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Signal bundle between the two cache refill requesters, the arbiter and
//   the single-ported 128-bit block memory.
//
//   Handshake (both requester ports): a port requests by raising exactly one
//   of READn/WRITEn (VALIDn = READn ^ WRITEn) with ADDRESSn/WRITEDATAn
//   stable. The arbiter holds BUSYWAITn high while the request is pending;
//   the single cycle where BUSYWAITn is low while VALIDn is high is the
//   completion window. READDATAn is valid in that window, and the requester
//   drops or changes its request there. The memory side uses the same
//   strobe/BUSYWAIT pairing with MEM_* signals.
//
//   modport slave  : arbiter view (requests in, memory commands out)
//   modport master : environment view (requesters plus memory)
interface mem_port_arbiter_if;
  logic         READ0;
  logic         WRITE0;
  logic [27:0]  ADDRESS0;
  logic [127:0] WRITEDATA0;
  logic [127:0] READDATA0;
  logic         BUSYWAIT0;

  logic         READ1;
  logic         WRITE1;
  logic [27:0]  ADDRESS1;
  logic [127:0] WRITEDATA1;
  logic [127:0] READDATA1;
  logic         BUSYWAIT1;

  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  logic         ERROR;

  modport slave (
    input  READ0, WRITE0, ADDRESS0, WRITEDATA0,
    output READDATA0, BUSYWAIT0,
    input  READ1, WRITE1, ADDRESS1, WRITEDATA1,
    output READDATA1, BUSYWAIT1,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output ERROR
  );

  modport master (
    output READ0, WRITE0, ADDRESS0, WRITEDATA0,
    input  READDATA0, BUSYWAIT0,
    output READ1, WRITE1, ADDRESS1, WRITEDATA1,
    input  READDATA1, BUSYWAIT1,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  ERROR
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter/sequencer in front of the single-ported block data
//   memory. Port 0 is the instruction-cache refill path, port 1 the
//   data-cache refill/writeback path. One access is outstanding at a time:
//   the winner's command is registered onto MEM_*, the memory BUSYWAIT is
//   tracked, read blocks are captured into the winner's READDATA, and the
//   winner is released with a one-cycle BUSYWAIT-low window.
//
//   Ports:
//     CLOCK      single clock, all state on posedge
//     RESET      asynchronous active-high reset
//     bus        mem_port_arbiter_if.slave (requester ports 0/1, memory
//                port, sticky ERROR timeout flag)
//     dbg_state  current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
//   Parameters:
//     ARB_MODE        0 = fixed priority to PRIORITY_PORT, 1 = round-robin
//     PRIORITY_PORT   port that wins fixed-priority ties
//     TIMEOUT_CYCLES  ACCESS-state cycle limit before ERROR is flagged
module mem_port_arbiter #(
  parameter bit ARB_MODE       = 1'b1,
  parameter bit PRIORITY_PORT  = 1'b1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLOCK,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q;
  logic            last_grant_q;
  logic [CW-1:0]   cnt_q;

  logic            mem_read_q;
  logic            mem_write_q;
  logic [27:0]     mem_address_q;
  logic [127:0]    mem_writedata_q;
  logic [127:0]    readdata0_q;
  logic [127:0]    readdata1_q;
  logic            error_q;

  logic            valid0;
  logic            valid1;
  logic            win;
  logic            win_port;
  logic            acc_exit;
  logic            acc_timeout;

  // Arbitration and exit conditions.
  always_comb begin
    // READ and WRITE together is not a request; the memory ignores it too.
    valid0   = bus.READ0 ^ bus.WRITE0;
    valid1   = bus.READ1 ^ bus.WRITE1;
    win      = (state_q == S_IDLE) && (valid0 || valid1);
    win_port = valid1;
    if (valid0 && valid1) begin
      win_port = ARB_MODE ? ~last_grant_q : PRIORITY_PORT;
    end
    // counter>=2 skips the first ACCESS cycle, where the memory may not
    // have raised its BUSYWAIT yet in response to the new strobe.
    acc_exit    = (state_q == S_ACCESS) && (cnt_q >= CW'(2)) && !bus.MEM_BUSYWAIT;
    acc_timeout = (state_q == S_ACCESS) && bus.MEM_BUSYWAIT &&
                  (cnt_q >= CW'(TIMEOUT_CYCLES));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win) state_d = S_ACCESS;
      S_ACCESS: if (acc_exit || acc_timeout) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command, capture and bookkeeping registers. Reset is asynchronous so
  // the memory strobes drop as soon as RESET rises.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b0;
      cnt_q           <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      readdata0_q     <= '0;
      readdata1_q     <= '0;
      error_q         <= 1'b0;
    end else if (win) begin
      grant_q         <= win_port;
      last_grant_q    <= win_port;
      mem_address_q   <= win_port ? bus.ADDRESS1   : bus.ADDRESS0;
      mem_writedata_q <= win_port ? bus.WRITEDATA1 : bus.WRITEDATA0;
      mem_read_q      <= win_port ? bus.READ1      : bus.READ0;
      mem_write_q     <= win_port ? bus.WRITE1     : bus.WRITE0;
      cnt_q           <= CW'(1);
    end else if (state_q == S_ACCESS) begin
      if (acc_exit) begin
        if (mem_read_q) begin
          if (grant_q) readdata1_q <= bus.MEM_READDATA;
          else         readdata0_q <= bus.MEM_READDATA;
        end
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else if (acc_timeout) begin
        // Abandon the access; the requester is released without new data.
        error_q     <= 1'b1;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else if (cnt_q < CW'(TIMEOUT_CYCLES)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // The stall rises combinationally with the request and opens only in DONE
  // for the granted port.
  always_comb begin
    bus.BUSYWAIT0 = valid0 && !((state_q == S_DONE) && (grant_q == 1'b0));
    bus.BUSYWAIT1 = valid1 && !((state_q == S_DONE) && (grant_q == 1'b1));
  end

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_address_q;
  assign bus.MEM_WRITEDATA = mem_writedata_q;
  assign bus.READDATA0     = readdata0_q;
  assign bus.READDATA1     = readdata1_q;
  assign bus.ERROR         = error_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. The main instance runs round-robin with an
//   8-cycle timeout against a behavioural block memory; a second instance
//   runs fixed priority to port 1 against an always-ready memory.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if fp_bus();
  logic [1:0] dbg_state;
  logic [1:0] fp_dbg_state;

  mem_port_arbiter #(
    .ARB_MODE(1'b1), .PRIORITY_PORT(1'b1), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(
    .ARB_MODE(1'b0), .PRIORITY_PORT(1'b1), .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .CLOCK(CLOCK), .RESET(RESET), .bus(fp_bus), .dbg_state(fp_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] mem_arr [0:63];  // memory device contents
  logic [127:0] shadow  [0:63];  // reference view of what memory should hold
  int mem_lat;                   // 0 = random latency per access
  bit mem_stuck;
  bit mem_active;
  bit mem_done;
  int mem_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural block memory ----------------
  initial begin
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = '0;
    mem_active = 1'b0;
    mem_done   = 1'b0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
        mem_active = 1'b0;
        mem_done   = 1'b0;
        bus.MEM_BUSYWAIT = 1'b0;
      end else if (!mem_active) begin
        mem_active = 1'b1;
        mem_done   = 1'b0;
        mem_cnt    = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 5));
        bus.MEM_BUSYWAIT = 1'b1;
      end else if (!mem_done && !mem_stuck) begin
        if (mem_cnt > 1) begin
          mem_cnt--;
        end else begin
          if (bus.MEM_WRITE) mem_arr[bus.MEM_ADDRESS[5:0]] = bus.MEM_WRITEDATA;
          else               bus.MEM_READDATA = mem_arr[bus.MEM_ADDRESS[5:0]];
          bus.MEM_BUSYWAIT = 1'b0;
          mem_done = 1'b1;
        end
      end
    end
  end

  // READDATAn may only change in port n's own read completion window.
  logic [127:0] prev_rd0 = '0;
  logic [127:0] prev_rd1 = '0;
  always begin
    @(posedge CLOCK);
    #4;
    if (!RESET && bus.READDATA0 !== prev_rd0)
      check("rd0_change_in_window", {127'd0, !bus.BUSYWAIT0 && bus.READ0}, 128'd1);
    if (!RESET && bus.READDATA1 !== prev_rd1)
      check("rd1_change_in_window", {127'd0, !bus.BUSYWAIT1 && bus.READ1}, 128'd1);
    prev_rd0 = bus.READDATA0;
    prev_rd1 = bus.READDATA1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit port, output int w);
    bit seen;
    seen = 1'b0;
    w = 0;
    while (!seen && w < 100) begin
      @(negedge CLOCK);
      w++;
      seen = port ? !bus.BUSYWAIT1 : !bus.BUSYWAIT0;
    end
    if (!seen) check(port ? "p1_done_bound" : "p0_done_bound", {127'd0, seen}, 128'd1);
  endtask

  task automatic wait_strobe(output int w);
    bit seen;
    seen = 1'b0;
    w = 0;
    while (!seen && w < 100) begin
      @(negedge CLOCK);
      w++;
      seen = bus.MEM_READ || bus.MEM_WRITE;
    end
    if (!seen) check("strobe_bound", {127'd0, seen}, 128'd1);
  endtask

  task automatic do_access(input bit port, input bit wr, input logic [27:0] addr,
                           input logic [127:0] data, output logic [127:0] rdata,
                           output int w);
    @(negedge CLOCK);
    if (!port) begin
      bus.READ0 = !wr; bus.WRITE0 = wr; bus.ADDRESS0 = addr; bus.WRITEDATA0 = data;
    end else begin
      bus.READ1 = !wr; bus.WRITE1 = wr; bus.ADDRESS1 = addr; bus.WRITEDATA1 = data;
    end
    wait_done(port, w);
    rdata = port ? bus.READDATA1 : bus.READDATA0;
    if (!port) begin bus.READ0 = 1'b0; bus.WRITE0 = 1'b0; end
    else       begin bus.READ1 = 1'b0; bus.WRITE1 = 1'b0; end
  endtask

  // Random traffic on one port within its own half of the address space, so
  // the two ports never race on a block and each port's model is in order.
  task automatic run_port(input bit port, input int n);
    logic [127:0] exp_q[$];
    logic [127:0] rd;
    logic [127:0] d;
    logic [27:0]  a;
    bit           wr;
    int           w;
    for (int i = 0; i < n; i++) begin
      a  = {22'd0, port, 5'($urandom_range(0, 31))};
      wr = 1'($urandom_range(0, 1));
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (wr) shadow[a[5:0]] = d;
      else    exp_q.push_back(shadow[a[5:0]]);
      do_access(port, wr, a, d, rd, w);
      if (!wr) check(port ? "p1_rand_rdata" : "p0_rand_rdata", rd, exp_q.pop_front());
      repeat ($urandom_range(0, 3)) @(negedge CLOCK);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] rd;
  logic [127:0] old_rd;
  int w;
  bit bw_ok;
  bit strobe_seen;
  bit addr_bad;
  int wins;

  initial begin
    bus.READ0 = 0; bus.WRITE0 = 0; bus.ADDRESS0 = '0; bus.WRITEDATA0 = '0;
    bus.READ1 = 0; bus.WRITE1 = 0; bus.ADDRESS1 = '0; bus.WRITEDATA1 = '0;
    fp_bus.READ0 = 0; fp_bus.WRITE0 = 0; fp_bus.ADDRESS0 = '0; fp_bus.WRITEDATA0 = '0;
    fp_bus.READ1 = 0; fp_bus.WRITE1 = 0; fp_bus.ADDRESS1 = '0; fp_bus.WRITEDATA1 = '0;
    fp_bus.MEM_BUSYWAIT = 1'b0;
    fp_bus.MEM_READDATA = {16{8'hC3}};
    mem_lat = 0;
    mem_stuck = 0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      shadow[i]  = mem_arr[i];
    end

    // Reset state
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    check("rst_mem_read",  bus.MEM_READ, 0);
    check("rst_mem_write", bus.MEM_WRITE, 0);
    check("rst_mem_addr",  bus.MEM_ADDRESS, 0);
    check("rst_mem_wdata", bus.MEM_WRITEDATA, 0);
    check("rst_rdata0",    bus.READDATA0, 0);
    check("rst_rdata1",    bus.READDATA1, 0);
    check("rst_error",     bus.ERROR, 0);
    check("rst_state",     dbg_state, 0);
    RESET = 1'b0;

    // Single read, memory busy for 5 cycles
    mem_lat = 5;
    mem_arr[16] = {16{8'hA5}};
    shadow[16]  = {16{8'hA5}};
    @(negedge CLOCK);
    bus.READ0 = 1'b1; bus.ADDRESS0 = 28'h0000010;
    #1 check("t1_bw0_rise", bus.BUSYWAIT0, 1);
    @(posedge CLOCK);
    #1;
    check("t1_mem_read", bus.MEM_READ, 1);
    check("t1_mem_addr", bus.MEM_ADDRESS, 28'h0000010);
    wait_done(1'b0, w);
    check("t1_latency", w, 7);
    check("t1_rdata0", bus.READDATA0, {16{8'hA5}});
    check("t1_done_strobe", bus.MEM_READ, 0);
    @(negedge CLOCK);
    check("t1_bw0_one_cycle", bus.BUSYWAIT0, 1);
    bus.READ0 = 1'b0;

    // Simultaneous requests, round-robin after reset: port 1 first
    mem_lat = 3;
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    bus.READ0 = 1'b1; bus.ADDRESS0 = 28'h1;
    bus.WRITE1 = 1'b1; bus.ADDRESS1 = 28'h2; bus.WRITEDATA1 = 128'h1234;
    @(posedge CLOCK);
    #1;
    check("t2_first_write", bus.MEM_WRITE, 1);
    check("t2_first_noread", bus.MEM_READ, 0);
    check("t2_first_addr", bus.MEM_ADDRESS, 28'h2);
    check("t2_first_wdata", bus.MEM_WRITEDATA, 128'h1234);
    bw_ok = 1'b1;
    w = 0;
    while (bus.BUSYWAIT1 && w < 100) begin
      @(negedge CLOCK);
      w++;
      bw_ok &= bus.BUSYWAIT0;
    end
    check("t2_p1_done", bus.BUSYWAIT1, 0);
    bus.WRITE1 = 1'b0;
    shadow[2] = 128'h1234;
    wait_strobe(w);
    bw_ok &= bus.BUSYWAIT0;
    check("t2_second_read", bus.MEM_READ, 1);
    check("t2_second_addr", bus.MEM_ADDRESS, 28'h1);
    w = 0;
    while (bus.BUSYWAIT0 && w < 100) begin
      @(negedge CLOCK);
      w++;
    end
    check("t2_bw0_held", {127'd0, bw_ok}, 1);
    check("t2_rdata0", bus.READDATA0, shadow[1]);
    bus.READ0 = 1'b0;
    check("t2_mem_block2", mem_arr[2], 128'h1234);

    // Illegal request: READ1 and WRITE1 together
    @(negedge CLOCK);
    bus.READ1 = 1'b1; bus.WRITE1 = 1'b1;
    #1 check("t3_bw1_low", bus.BUSYWAIT1, 0);
    strobe_seen = 1'b0;
    bw_ok = 1'b1;
    repeat (4) begin
      @(negedge CLOCK);
      strobe_seen |= bus.MEM_READ | bus.MEM_WRITE;
      bw_ok &= (dbg_state == 2'd0);
    end
    check("t3_no_strobe", {127'd0, strobe_seen}, 0);
    check("t3_stay_idle", {127'd0, bw_ok}, 1);
    bus.READ1 = 1'b0; bus.WRITE1 = 1'b0;

    // Timeout: memory never drops BUSYWAIT
    mem_stuck = 1'b1;
    old_rd = bus.READDATA0;
    do_access(1'b0, 1'b0, 28'h3, '0, rd, w);
    check("t4_timeout_latency", w, 9);
    check("t4_error", bus.ERROR, 1);
    check("t4_rdata_kept", rd, old_rd);
    mem_stuck = 1'b0;
    do_access(1'b1, 1'b1, 28'd40, 128'hBEEF_0001, rd, w);
    shadow[40] = 128'hBEEF_0001;
    do_access(1'b1, 1'b0, 28'd40, '0, rd, w);
    check("t4_after_rdata", rd, 128'hBEEF_0001);
    check("t4_error_sticky", bus.ERROR, 1);

    // Reset in the middle of a port-0 read, port 1 pending
    mem_lat = 5;
    @(negedge CLOCK);
    bus.READ0 = 1'b1; bus.ADDRESS0 = 28'd4;
    @(posedge CLOCK);
    repeat (3) @(negedge CLOCK);
    bus.READ1 = 1'b1; bus.ADDRESS1 = 28'd33;
    check("t5_pre_strobe", bus.MEM_READ, 1);
    RESET = 1'b1;
    #1;
    check("t5_strobe_async", bus.MEM_READ, 0);
    check("t5_rdata0", bus.READDATA0, 0);
    check("t5_error", bus.ERROR, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    wait_strobe(w);
    check("t5_p1_addr", bus.MEM_ADDRESS, 28'd33);
    wait_done(1'b1, w);
    check("t5_p1_rdata", bus.READDATA1, shadow[33]);
    bus.READ1 = 1'b0;
    wait_done(1'b0, w);
    check("t5_p0_rdata", bus.READDATA0, shadow[4]);
    bus.READ0 = 1'b0;

    // Random traffic on both ports concurrently
    mem_lat = 0;
    fork
      run_port(1'b0, 20);
      run_port(1'b1, 20);
    join
    check("rand_no_error", bus.ERROR, 0);

    // Fixed priority to port 1: port 0 starves while port 1 keeps reading
    @(negedge CLOCK);
    fp_bus.READ0 = 1'b1; fp_bus.ADDRESS0 = 28'd5;
    fp_bus.READ1 = 1'b1; fp_bus.ADDRESS1 = 28'd6;
    bw_ok = 1'b1;
    addr_bad = 1'b0;
    wins = 0;
    repeat (40) begin
      @(negedge CLOCK);
      bw_ok &= fp_bus.BUSYWAIT0;
      if (!fp_bus.BUSYWAIT1) wins++;
      if (fp_bus.MEM_READ && fp_bus.MEM_ADDRESS != 28'd6) addr_bad = 1'b1;
    end
    check("fp_bw0_starved", {127'd0, bw_ok}, 1);
    check("fp_p1_served", {127'd0, wins >= 9}, 1);
    check("fp_only_p1_addr", {127'd0, addr_bad}, 0);
    check("fp_p1_rdata", fp_bus.READDATA1, {16{8'hC3}});
    check("fp_p0_untouched", fp_bus.READDATA0, 0);
    fp_bus.READ1 = 1'b0;
    w = 0;
    while (fp_bus.BUSYWAIT0 && w < 100) begin
      @(negedge CLOCK);
      w++;
    end
    check("fp_p0_served", fp_bus.BUSYWAIT0, 0);
    check("fp_p0_rdata", fp_bus.READDATA0, {16{8'hC3}});
    fp_bus.READ0 = 1'b0;

    repeat (2) @(negedge CLOCK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
